// File: rtl/dmem_port_arbiter.sv
// Arbitrates the CPU (C) and debug (D) ports onto the data memory's single port and formats accesses.
// Latency: grant is combinational, load data and err arrive one cycle after the grant; one access per cycle.
// Backpressure: requesters hold req until gnt; D is forced through after STARVE_LIMIT consecutive lost cycles.
module dmem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [1:0]  c_size,
    input  logic        c_signed,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_write_en,
    output logic [31:0] mem_in_data,
    input  logic [31:0] mem_out_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  wait_cnt;
    logic        sel_d;
    logic        any_gnt;
    logic        a_we;
    logic        a_signed;
    logic [1:0]  a_size;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_err;
    logic [3:0]  a_be;
    logic [31:0] a_wrep;

    logic        rsp_vld;
    logic        rsp_err;
    logic        rsp_own_d;
    logic [1:0]  rsp_size;
    logic        rsp_signed;
    logic [1:0]  rsp_off;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_data;

    always_comb begin
        sel_d = d_req && (!c_req || (wait_cnt == LIMIT));
        d_gnt = rst_n && sel_d;
        c_gnt = rst_n && c_req && !sel_d;
    end

    assign any_gnt = c_gnt || d_gnt;

    // Without a D grant the C fields drive the port, so mem_addr idles on the C address.
    assign a_we     = d_gnt ? d_we     : c_we;
    assign a_size   = d_gnt ? d_size   : c_size;
    assign a_signed = d_gnt ? d_signed : c_signed;
    assign a_addr   = d_gnt ? d_addr   : c_addr;
    assign a_wdata  = d_gnt ? d_wdata  : c_wdata;

    always_comb begin
        a_err  = 1'b0;
        a_be   = 4'b0000;
        a_wrep = a_wdata;
        case (a_size)
            2'b00: begin
                a_be   = 4'b0001 << a_addr[1:0];
                a_wrep = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                a_err  = a_addr[0];
                a_be   = 4'b0011 << {a_addr[1], 1'b0};
                a_wrep = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                a_err  = |a_addr[1:0];
                a_be   = 4'b1111;
            end
            default: a_err = 1'b1;
        endcase
    end

    assign mem_addr     = a_addr[31:2];
    assign mem_in_data  = a_wrep;
    assign mem_write_en = (any_gnt && a_we && !a_err) ? a_be : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!d_req || d_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Response register is rewritten every cycle, so back-to-back grants stay in order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld    <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_own_d  <= 1'b0;
            rsp_size   <= 2'b00;
            rsp_signed <= 1'b0;
            rsp_off    <= 2'b00;
        end else begin
            rsp_vld    <= any_gnt && !a_we && !a_err;
            rsp_err    <= any_gnt && a_err;
            rsp_own_d  <= d_gnt;
            rsp_size   <= a_size;
            rsp_signed <= a_signed;
            rsp_off    <= a_addr[1:0];
        end
    end

    always_comb begin
        lane_b = mem_out_data[{rsp_off, 3'b000} +: 8];
        lane_h = rsp_off[1] ? mem_out_data[31:16] : mem_out_data[15:0];
        case (rsp_size)
            2'b00:   ld_data = {{24{rsp_signed & lane_b[7]}}, lane_b};
            2'b01:   ld_data = {{16{rsp_signed & lane_h[15]}}, lane_h};
            default: ld_data = mem_out_data;
        endcase
    end

    assign c_rvalid = rsp_vld && !rsp_own_d;
    assign d_rvalid = rsp_vld && rsp_own_d;
    assign c_err    = rsp_err && !rsp_own_d;
    assign d_err    = rsp_err && rsp_own_d;
    assign c_rdata  = c_rvalid ? ld_data : 32'd0;
    assign d_rdata  = d_rvalid ? ld_data : 32'd0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: memory model, byte-level reference memory and a response scoreboard.
module tb_dmem_port_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        c_req, c_we, c_signed, c_gnt, c_rvalid, c_err;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_signed, d_gnt, d_rvalid, d_err;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_in_data, mem_out_data;

    dmem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_signed(c_signed),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_in_data(mem_in_data), .mem_out_data(mem_out_data)
    );

    // Data memory: 4096 words, byte enables, registered read, upper address bits must be zero.
    logic [31:0] mem_arr [0:4095];
    logic        mem_clear;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) mem_arr[i] <= (i == 1) ? 32'h0000000B : 32'd0;
            mem_out_data <= 32'd0;
        end else if (mem_addr[29:12] == 18'd0) begin
            for (int i = 0; i < 4; i++)
                if (mem_write_en[i]) mem_arr[mem_addr[11:0]][8*i +: 8] <= mem_in_data[8*i +: 8];
            mem_out_data <= mem_arr[mem_addr[11:0]];
        end else begin
            mem_out_data <= 32'd0;
        end
    end

    typedef struct {
        bit        idle;
        bit        we;
        bit [1:0]  size;
        bit        sgn;
        bit [31:0] addr;
        bit [31:0] wdata;
    } op_t;

    typedef struct {
        int        due;
        bit        port_d;
        bit        is_err;
        bit [31:0] data;
    } exp_t;

    op_t   c_q[$], d_q[$];
    op_t   c_op, d_op;
    bit    c_act, d_act;
    exp_t  exp_q[$];
    byte unsigned ref_mem [int unsigned];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    d_wait;
    bit    mon_en = 1'b0;
    bit    reset_next;
    string glog;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic op_t mk(bit we, bit [1:0] sz, bit sg, bit [31:0] a, bit [31:0] wd);
        op_t o;
        o.idle = 1'b0; o.we = we; o.size = sz; o.sgn = sg; o.addr = a; o.wdata = wd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o = mk($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
               $urandom_range(0, 63), $urandom);
        if ($urandom_range(0, 15) == 0) o.addr = 32'h0001_0000 + $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0 && o.size == 2'b11) o.size = 2'b10;
        o.idle = ($urandom_range(0, 3) == 0);
        return o;
    endfunction

    function automatic byte unsigned rd_ref(int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'd0;
    endfunction

    task automatic drive();
        if (!c_act && c_q.size() > 0) begin c_op = c_q.pop_front(); c_act = !c_op.idle; end
        if (!d_act && d_q.size() > 0) begin d_op = d_q.pop_front(); d_act = !d_op.idle; end
        c_req = c_act; c_we = c_op.we; c_size = c_op.size; c_signed = c_op.sgn;
        c_addr = c_op.addr; c_wdata = c_op.wdata;
        d_req = d_act; d_we = d_op.we; d_size = d_op.size; d_signed = d_op.sgn;
        d_addr = d_op.addr; d_wdata = d_op.wdata;
    endtask

    // Expected memory-side behaviour and response for one granted request.
    task automatic grant(input bit pd, input op_t op, output bit pushed);
        int          nb;
        bit          er, inr;
        logic [3:0]  be;
        logic [31:0] wd, v;
        exp_t        e;
        nb  = 1 << op.size;
        er  = (op.size == 2'b11) || ((op.addr % nb) != 0);
        inr = (op.addr >> 14) == 0;
        pushed = 1'b0;
        check("mem_addr", 80'(mem_addr), 80'(op.addr >> 2));
        if (er) begin
            check("err_we", 80'(mem_write_en), 80'd0);
            e.due = cyc + 1; e.port_d = pd; e.is_err = 1'b1; e.data = 32'd0;
            exp_q.push_back(e); pushed = 1'b1;
        end else if (op.we) begin
            be = 4'd0; wd = 32'd0;
            for (int i = 0; i < nb; i++) be[(op.addr % 4) + i] = 1'b1;
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = op.wdata[8*(i % nb) +: 8];
            check("st_we", 80'(mem_write_en), 80'(be));
            check("st_data", 80'(mem_in_data), 80'(wd));
            if (inr) for (int i = 0; i < nb; i++) ref_mem[op.addr + i] = op.wdata[8*i +: 8];
        end else begin
            check("ld_we", 80'(mem_write_en), 80'd0);
            v = 32'd0;
            if (inr) for (int i = 0; i < nb; i++) v[8*i +: 8] = rd_ref(op.addr + i);
            if (op.sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
            e.due = cyc + 1; e.port_d = pd; e.is_err = 1'b0; e.data = v;
            exp_q.push_back(e); pushed = 1'b1;
        end
    endtask

    task automatic cycle();
        bit ec, ed, pushed;
        drive();
        #3;
        ed = rst_n && d_act && (!c_act || d_wait >= LIMIT);
        ec = rst_n && c_act && !ed;
        check("gnt", 80'({c_gnt, d_gnt}), 80'({ec, ed}));
        if (!rst_n || !d_act || ed) d_wait = 0;
        else if (d_wait < LIMIT) d_wait++;
        pushed = 1'b0;
        if (ec) begin
            glog = {glog, "C"}; grant(1'b0, c_op, pushed); c_act = 1'b0;
        end else if (ed) begin
            glog = {glog, "D"}; grant(1'b1, d_op, pushed); d_act = 1'b0;
        end else begin
            glog = {glog, "-"};
            check("idle_we", 80'(mem_write_en), 80'd0);
            check("idle_addr", 80'(mem_addr), 80'(c_addr[31:2]));
        end
        if (reset_next) begin
            if (pushed) void'(exp_q.pop_back());
            rst_n = 1'b0;
            reset_next = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int bound);
        int n;
        n = 0;
        while ((c_q.size() > 0 || d_q.size() > 0 || c_act || d_act) && n < bound) begin
            cycle();
            n++;
        end
        check("drain", 80'(n < bound), 80'd1);
        repeat (2) cycle();
    endtask

    task automatic check_log(input string name, input string exp);
        total++;
        if (glog != exp) begin
            bad++;
            $display("FAIL %s: got %s expected %s", name, glog, exp);
        end
    endtask

    // Scoreboard monitor: each cycle either the due response or all-quiet outputs.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [3:0]  ef;
        logic [31:0] cd, dd;
        if (mon_en) begin
            ef = 4'd0; cd = 32'd0; dd = 32'd0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e  = exp_q.pop_front();
                ef = {!e.port_d && !e.is_err, !e.port_d && e.is_err,
                      e.port_d && !e.is_err, e.port_d && e.is_err};
                cd = ef[3] ? e.data : 32'd0;
                dd = ef[1] ? e.data : 32'd0;
            end
            check("resp", 80'({c_rvalid, c_err, d_rvalid, d_err, c_rdata, d_rdata}),
                  80'({ef, cd, dd}));
        end
    end

    initial begin
        rst_n = 1'b0; mem_clear = 1'b1; reset_next = 1'b0; d_wait = 0;
        c_act = 1'b0; d_act = 1'b0;
        c_op = mk(0, 0, 0, 0, 0); c_op.idle = 1'b1; d_op = c_op;
        ref_mem[4] = 8'h0B;
        drive();
        @(posedge clk); #1;
        mon_en = 1'b1;
        // Requests held through reset must not be granted.
        c_q.push_back(mk(0, 2'b10, 0, 32'h4, 0));
        d_q.push_back(mk(0, 2'b10, 0, 32'h8, 0));
        cycle(); cycle();
        mem_clear = 1'b0; rst_n = 1'b1;
        run_idle(20);

        // Word, half and byte stores and loads on C.
        c_q.push_back(mk(0, 2'b10, 0, 32'h4, 0));
        c_q.push_back(mk(1, 2'b01, 0, 32'h6, 32'h1234BEEF));
        c_q.push_back(mk(0, 2'b01, 1, 32'h6, 0));
        c_q.push_back(mk(0, 2'b10, 0, 32'h4, 0));
        c_q.push_back(mk(1, 2'b00, 0, 32'h5, 32'h00000080));
        c_q.push_back(mk(0, 2'b00, 1, 32'h5, 0));
        c_q.push_back(mk(0, 2'b00, 0, 32'h5, 0));
        c_q.push_back(mk(0, 2'b01, 0, 32'h6, 0));
        run_idle(40);

        // Alignment errors, including an erroring store, and out-of-range accesses.
        c_q.push_back(mk(0, 2'b01, 1, 32'h3, 0));
        c_q.push_back(mk(0, 2'b11, 0, 32'h8, 0));
        c_q.push_back(mk(1, 2'b10, 0, 32'h6, 32'hDEADBEEF));
        c_q.push_back(mk(0, 2'b10, 0, 32'h4, 0));
        c_q.push_back(mk(0, 2'b10, 0, 32'h0001_0000, 0));
        c_q.push_back(mk(1, 2'b10, 0, 32'h0001_0004, 32'hCAFEF00D));
        c_q.push_back(mk(0, 2'b00, 1, 32'h0001_0004, 0));
        d_q.push_back(mk(1, 2'b00, 0, 32'h23, 32'h000000F1));
        run_idle(40);
        d_q.push_back(mk(0, 2'b00, 1, 32'h23, 0));
        d_q.push_back(mk(0, 2'b01, 0, 32'h21, 0));
        run_idle(20);

        // Continuous contention: D is forced through every fifth cycle.
        glog = "";
        for (int i = 0; i < 8; i++) c_q.push_back(mk(0, 2'b10, 0, 32'(4 * i), 0));
        d_q.push_back(mk(0, 2'b00, 0, 32'h23, 0));
        d_q.push_back(mk(0, 2'b10, 0, 32'h4, 0));
        cycle();
        while (c_act || d_act || c_q.size() > 0 || d_q.size() > 0) begin
            if (glog.len() > 20) break;
            cycle();
        end
        check_log("starve_seq", "CCCCDCCCCD");
        repeat (2) cycle();

        // Reset right after a load grant drops the response and clears the D wait count.
        c_q.push_back(mk(0, 2'b10, 0, 32'h0, 0));
        c_q.push_back(mk(0, 2'b10, 0, 32'h4, 0));
        d_q.push_back(mk(0, 2'b10, 0, 32'h8, 0));
        cycle();
        reset_next = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;
        glog = "";
        for (int i = 0; i < 4; i++) c_q.push_back(mk(0, 2'b10, 0, 32'(8 + 4 * i), 0));
        run_idle(20);
        check_log("post_reset_seq", "CCCCD--");

        // Randomised traffic on both ports.
        for (int i = 0; i < 200; i++) begin
            c_q.push_back(rand_op());
            d_q.push_back(rand_op());
        end
        run_idle(3000);

        check("leftover", 80'(exp_q.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
